// File: rtl/skein1024_ubi_ctrl_pkg.sv
// Constants, state encoding and key/tweak helpers shared by the Skein-1024 UBI controller.
package skein_pkg;
  localparam logic [63:0] C240        = 64'h1BD1_1BDA_A9FC_1A22;
  localparam logic [5:0]  TYPE_MSG    = 6'd48;
  localparam logic [5:0]  TYPE_OUT    = 6'd63;
  localparam int          BLOCK_BYTES = 128;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    NEXT,
    MSG_BUSY,
    OUT_BUSY,
    DONE
  } state_t;

  function automatic logic [1087:0] skein_key_parity(input logic [1023:0] cv);
    logic [63:0] par;
    par = C240;
    for (int j = 0; j < 16; j++) par = par ^ cv[64*j +: 64];
    return {par, cv};
  endfunction

  // t1 packs {final, first, type, reserved, pos[95:64]}
  function automatic logic [191:0] skein_tweak(input logic [95:0] pos, input logic first,
                                               input logic fin, input logic [5:0] typ);
    logic [63:0] t0;
    logic [63:0] t1;
    t0 = pos[63:0];
    t1 = {fin, first, typ, 24'h0, pos[95:64]};
    return {t0 ^ t1, t1, t0};
  endfunction
endpackage

// File: rtl/skein1024_ubi_ctrl_if.sv
// Message, core and digest signals of the Skein-1024 UBI controller.
interface skein1024_ubi_ctrl_if;
  logic [1023:0] iv;
  logic          msg_valid;
  logic          msg_ready;
  logic [1023:0] msg_data;
  logic [7:0]    msg_bytes;
  logic          msg_last;
  logic          core_valid;
  logic [1023:0] core_state;
  logic [1087:0] core_key;
  logic [191:0]  core_type;
  logic [1023:0] core_out;
  logic          core_out_valid;
  logic          hash_valid;
  logic [1023:0] hash_data;
  logic          hash_ready;

  modport master (
    output iv, msg_valid, msg_data, msg_bytes, msg_last, core_out, core_out_valid, hash_ready,
    input  msg_ready, core_valid, core_state, core_key, core_type, hash_valid, hash_data
  );

  modport slave (
    input  iv, msg_valid, msg_data, msg_bytes, msg_last, core_out, core_out_valid, hash_ready,
    output msg_ready, core_valid, core_state, core_key, core_type, hash_valid, hash_data
  );
endinterface

// File: rtl/skein1024_ubi_ctrl_key_tweak_gen.sv
// Combinational chaining value -> extended key, and position/flags/type -> tweak.
module skein_key_tweak_gen
  import skein_pkg::*;
(
  input  logic [1023:0] cv,
  input  logic [95:0]   pos,
  input  logic          first,
  input  logic          fin,
  input  logic [5:0]    typ,
  output logic [1087:0] key,
  output logic [191:0]  tweak
);
  assign key   = skein_key_parity(cv);
  assign tweak = skein_tweak(pos, first, fin, typ);
endmodule

// File: rtl/skein1024_ubi_ctrl.sv
// UBI chaining controller in front of the pipelined Skein-1024 block core; one block in flight.
//   state    | meaning
//   DRAIN    | flush stale core results after reset
//   IDLE     | waiting for the first block of a message
//   NEXT     | waiting for a follow-on block of the current message
//   MSG_BUSY | message block in the core
//   OUT_BUSY | output block in the core
//   DONE     | digest held until consumed
module skein1024_ubi_ctrl
  import skein_pkg::*;
#(
  parameter int CORE_LATENCY = 121
) (
  input logic clk,
  input logic rst,
  skein1024_ubi_ctrl_if.slave bus
);
  localparam int            CW         = $clog2(CORE_LATENCY + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(CORE_LATENCY - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] drain_cnt;
  logic [1023:0] cv;
  logic [1023:0] blk;
  logic [95:0]   pos;
  logic          blk_last;
  logic [7:0]    nbytes;
  logic [1023:0] blk_masked;
  logic          accept;
  logic          res_msg;
  logic          res_out;
  logic          issue_out;
  logic [1023:0] gen_cv;
  logic [95:0]   gen_pos;
  logic          gen_first;
  logic          gen_fin;
  logic [5:0]    gen_type;
  logic [1087:0] gen_key;
  logic [191:0]  gen_tweak;

  assign accept    = bus.msg_valid & bus.msg_ready;
  assign res_msg   = bus.core_out_valid & (state == MSG_BUSY);
  assign res_out   = bus.core_out_valid & (state == OUT_BUSY);
  assign issue_out = res_msg & blk_last;
  assign nbytes    = (bus.msg_bytes > 8'd128) ? 8'd128 : bus.msg_bytes;

  always_comb begin
    blk_masked = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (i < int'(nbytes)) blk_masked[8*i +: 8] = bus.msg_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DRAIN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DRAIN:      if (drain_cnt == '0) state_nxt = IDLE;
      IDLE, NEXT: if (accept) state_nxt = MSG_BUSY;
      MSG_BUSY:   if (res_msg) state_nxt = blk_last ? OUT_BUSY : NEXT;
      OUT_BUSY:   if (res_out) state_nxt = DONE;
      DONE:       if (bus.hash_ready) state_nxt = IDLE;
      default:    state_nxt = DRAIN;
    endcase
  end

  // One generator serves both issue paths: message accept and output block after the last result.
  always_comb begin
    if (state == MSG_BUSY) begin
      gen_cv    = bus.core_out ^ blk;
      gen_pos   = 96'd8;
      gen_first = 1'b1;
      gen_fin   = 1'b1;
      gen_type  = TYPE_OUT;
    end else begin
      gen_cv    = (state == IDLE) ? bus.iv : cv;
      gen_pos   = ((state == IDLE) ? 96'd0 : pos) + {88'd0, nbytes};
      gen_first = (state == IDLE);
      gen_fin   = bus.msg_last;
      gen_type  = TYPE_MSG;
    end
  end

  skein_key_tweak_gen u_gen (
    .cv    (gen_cv),
    .pos   (gen_pos),
    .first (gen_first),
    .fin   (gen_fin),
    .typ   (gen_type),
    .key   (gen_key),
    .tweak (gen_tweak)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt      <= DRAIN_LOAD;
      cv             <= '0;
      blk            <= '0;
      pos            <= '0;
      blk_last       <= 1'b0;
      bus.msg_ready  <= 1'b0;
      bus.core_valid <= 1'b0;
      bus.core_state <= '0;
      bus.core_key   <= '0;
      bus.core_type  <= '0;
      bus.hash_valid <= 1'b0;
      bus.hash_data  <= '0;
    end else begin
      bus.core_valid <= 1'b0;
      bus.msg_ready  <= (state_nxt == IDLE) || (state_nxt == NEXT);
      if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      if (accept) begin
        blk            <= blk_masked;
        blk_last       <= bus.msg_last;
        pos            <= gen_pos;
        cv             <= gen_cv;
        bus.core_valid <= 1'b1;
        bus.core_state <= blk_masked;
        bus.core_key   <= gen_key;
        bus.core_type  <= gen_tweak;
      end
      if (res_msg) cv <= gen_cv;
      if (issue_out) begin
        bus.core_valid <= 1'b1;
        bus.core_state <= '0;
        bus.core_key   <= gen_key;
        bus.core_type  <= gen_tweak;
      end
      // Output block feed-forward is with an all-zero state, so the result is the digest.
      if (res_out) begin
        bus.hash_data  <= bus.core_out;
        bus.hash_valid <= 1'b1;
      end
      if (state == DONE && bus.hash_ready) bus.hash_valid <= 1'b0;
    end
  end
endmodule

// File: doc/skein1024_ubi_ctrl.md
# skein1024_ubi_ctrl

UBI chaining controller that sits directly upstream of the Skein-1024 pipelined block core (`Skein1024Block`). It accepts 1024-bit message blocks, builds each block's 1088-bit extended key (chaining value plus parity word) and 192-bit tweak, and issues the block to the core. It applies the UBI feed-forward XOR to each core result, then runs the final output-stage UBI block and returns the 1024-bit digest. It keeps exactly one block in flight.

## Interface
Parameters:
- `CORE_LATENCY`, 121: cycles from `core_valid` to the matching `core_out_valid`; also the post-reset drain length.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `iv`  in  1024  initial chaining value (config-UBI result); sampled when the first block of a message is accepted.
- `msg_valid`  in  1  message block present.
- `msg_ready`  out  1  block will be accepted this cycle.
- `msg_data`  in  1024  block; byte i is at bits [8i+7:8i]; 64-bit words are little-endian.
- `msg_bytes`  in  8  valid bytes in the block, 0..128; values above 128 are clamped to 128.
- `msg_last`  in  1  final block of the message.
- `core_valid`  out  1  drives `DataValid`; one-cycle pulse.
- `core_state`  out  1024  drives `InState`.
- `core_key`  out  1088  drives `InKey`.
- `core_type`  out  192  drives `InType`.
- `core_out`  in  1024  from `OutState`.
- `core_out_valid`  in  1  from `OutputValid`.
- `hash_valid`  out  1  digest available.
- `hash_data`  out  1024  digest.
- `hash_ready`  in  1  digest consumed.

## Operation
- **Reset values:** `msg_ready`=0, `core_valid`=0, `hash_valid`=0; all data outputs are 0; state is DRAIN.
- **States:** DRAIN, IDLE, NEXT, MSG_BUSY, OUT_BUSY, DONE.
- **DRAIN:**
  - Counts `CORE_LATENCY` cycles, then moves to IDLE.
  - The core has no reset, so any `core_out_valid` seen in DRAIN is ignored.
- **IDLE / NEXT:**
  - `msg_ready`=1.
  - On accept: CV is loaded from `iv` in IDLE, and the existing CV is kept in NEXT.
  - The masked block is latched: bytes ≥ `msg_bytes` are forced to 0.
  - pos += `msg_bytes` (clamped); pos is 96 bits and wraps modulo 2^96.
  - One `core_valid` pulse is issued; state moves to MSG_BUSY.
- **Key:** k0..k15 = CV; k16 = C240 ^ k0 ^ … ^ k15, where C240 = 0x1BD11BDAA9FC1A22. Word j sits at bits [64j+63:64j].
- **Tweak:**
  - t0 = pos[63:0].
  - t1 = {final, first, type[5:0], 24'b0, pos[95:64]}.
  - t2 = t0 ^ t1.
  - `core_type` = {t2, t1, t0}.
  - Message blocks use type 48; the output block uses type 63.
  - `first` is set on the first block of a message; `final` = `msg_last`.
- **MSG_BUSY:**
  - On `core_out_valid`: CV ← `core_out` ^ latched block.
  - If the block was last: issue the output block and go to OUT_BUSY. Otherwise go to NEXT.
- **Output block:**
  - state = 0; key from the new CV; pos = 8; first = final = 1; type 63.
- **OUT_BUSY:**
  - On `core_out_valid`: `hash_data` ← `core_out` (feed-forward with zero).
  - `hash_valid`=1; go to DONE.
- **DONE:**
  - Hold `hash_valid`/`hash_data` until `hash_ready`, then go to IDLE.
  - `msg_ready`=0 while in DONE.
- **Empty message:** the first block with `msg_bytes`=0 and `msg_last`=1 issues an all-zero block with pos=0.
- **Short non-last block:** a non-last block with `msg_bytes`<128 is accepted as given (masked); its padding is the sender's responsibility.
- **Stray valid:** `core_out_valid` in IDLE, NEXT or DONE is ignored.
- **Reset mid-operation:** any state returns to DRAIN, and in-flight core results are discarded.

## Timing
- **Outputs:** all outputs are registered.
- **Issue:** `core_valid` and the `core_*` buses are valid in the cycle after the accept edge.
- **Data hold:** `core_state`/`core_key`/`core_type` stay stable until the next issue.
- **Result to next issue:** from the edge sampling `core_out_valid`, CV updates on that edge. For a last block, the output-block `core_valid` follows in the next cycle.
- **Per-block delay:** NEXT is entered on the same edge, so `msg_ready`=1 in the following cycle. The core is in flight for `CORE_LATENCY`+1 cycles per block.
- **Digest:** `hash_valid` rises in the cycle after the output-block result.
- **Latency:** single-block message, accept to `hash_valid` = 2·`CORE_LATENCY`+3 cycles.

## Structure
- **Package `skein_pkg`:**
  - Constants: C240, TYPE_MSG=48, TYPE_OUT=63, BLOCK_BYTES=128.
  - Functions: `skein_key_parity()` and `skein_tweak()`.
  - State enum.
- **Sub-module `skein_key_tweak_gen`:** combinational CV→1088-bit key and pos/flags/type→192-bit tweak. It is instanced once, with its output registered in the controller.

## Test plan
- **Reset drain:**
  - Stimulus: assert `rst` mid-MSG_BUSY while the stub core returns a stale `core_out_valid`.
  - Required: `msg_ready` stays 0 for `CORE_LATENCY` cycles; the stale result is ignored; no `hash_valid`.
- **Single 1-byte message 0xFF, iv=0, stub core:**
  - Message block: `core_key`[1087:1024]=0x1BD11BDAA9FC1A22; t0=1; t1=0xF000000000000000; t2=0xF000000000000001; `core_state`=0x…00FF.
  - Output block: t0=8; t1=0xFF00000000000000; t2=0xFF00000000000008; `core_state`=0.
- **Two-block message (128 + 88 bytes):**
  - Block 1: t0=128, t1=0x7000000000000000.
  - Block 2: t0=216, t1=0xB000000000000000.
  - CV for block 2 = stub output ^ block 1; `msg_ready`=0 during MSG_BUSY.
- **Empty message:** pos=0; `core_state`=0; t1=0xF000000000000000; then the output block is issued.
- **Backpressure:**
  - Stimulus: `hash_ready`=0 for 20 cycles.
  - Required: `hash_valid`/`hash_data` are stable and `msg_ready`=0 throughout; after the `hash_ready` edge, `msg_ready`=1 next cycle.
- **Full-core Skein-1024-1024 KAT:** with the real `Skein1024Block` and `CORE_LATENCY`=121, the digest matches the Skein 1.3 KATs for the 1-byte, 128-byte and 256-byte vectors.
